// File: rtl/nibble_add_pkg.sv
// nibble_add_pkg: shared constants, FSM state type and sizing helper for the
// nibble-serial adder sequencer.
//   NIBBLE_W  width of one adder slice (bits)
//   state_t   sequencer states
//   idx_w()   width of the nibble index counter for a given nibble count
package nibble_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A single-nibble operand still needs a 1-bit index register.
  function automatic int idx_w(input int nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/add4_ci.sv
// add4_ci: combinational 4-bit ripple full-adder chain with carry-in.
//   a, b  in  4  addends
//   ci    in  1  carry-in
//   s     out 4  sum
//   co    out 1  carry-out
module add4_ci
  import nibble_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [NIBBLE_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[NIBBLE_W];

endmodule

// File: rtl/nibble_add_seq.sv
// nibble_add_seq: nibble-serial adder. Operands accepted over a valid/ready
// handshake are summed one nibble per clock, LSB nibble first, through a single
// add4_ci slice with the carry held in a register between slices. The result is
// offered over a second valid/ready handshake.
//
// Optional feature macro: NIBBLE_ADD_SUB_EN adds the `sub` port (A-B).
//
// Ports:
//   clk        in  1  clock, rising edge
//   rst_n      in  1  async active-low reset
//   in_valid   in  1  operands present
//   in_ready   out 1  idle, operands accepted this cycle if in_valid
//   a, b       in  W  operands (W = 4*NIBBLES)
//   sub        in  1  subtract select (NIBBLE_ADD_SUB_EN only)
//   out_valid  out 1  result available
//   out_ready  in  1  consumer takes the result
//   sum        out W  result
//   co         out 1  final carry-out (1 = no borrow when subtracting)
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// ADD   | one nibble summed per clock, idx selects the nibble
// DONE  | result held, out_valid=1 until out_ready
module nibble_add_seq
  import nibble_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b,
`ifdef NIBBLE_ADD_SUB_EN
  input  logic                          sub,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]   sum,
  output logic                          co
);

  localparam int IW = idx_w(NIBBLES);

  state_t state_q, state_nxt;

  logic [NIBBLES-1:0][NIBBLE_W-1:0] a_q, b_q, sum_q;
  logic [IW-1:0]                    idx_q;
  logic                             carry_q;
  logic                             sub_q;

  logic [NIBBLE_W-1:0] a_nib, b_nib, b_eff, s_nib;
  logic                slice_co;
  logic                accept;
  logic                last_nib;

  assign accept   = in_valid & in_ready;
  assign last_nib = (idx_q == IW'(NIBBLES - 1));

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_nxt = ST_ADD;
      ST_ADD:  if (last_nib)  state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs, decoded from registered state only
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  // Nibble select as a decoded mux so NIBBLES=1 needs no zero-width index.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IW'(i)) begin
        a_nib = a_q[i];
        b_nib = b_q[i];
      end
    end
  end

`ifdef NIBBLE_ADD_SUB_EN
  assign b_eff = sub_q ? ~b_nib : b_nib;
`else
  assign b_eff = b_nib;
`endif

  add4_ci u_slice (
    .a  (a_nib),
    .b  (b_eff),
    .ci (carry_q),
    .s  (s_nib),
    .co (slice_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      idx_q <= '0;
`ifdef NIBBLE_ADD_SUB_EN
      // Subtract seeds the carry with 1 to complete the two's complement of b.
      sub_q   <= sub;
      carry_q <= sub;
`else
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
`endif
    end else if (state_q == ST_ADD) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx_q == IW'(i)) sum_q[i] <= s_nib;
      end
      carry_q <= slice_co;
      idx_q   <= idx_q + IW'(1);
    end
  end

  assign sum = sum_q;
  assign co  = carry_q;

endmodule

// File: doc/nibble_add_seq.md
# nibble_add_seq

Nibble-serial adder sequencer: accepts two `4*NIBBLES`-bit operands over a valid/ready handshake. It time-shares a single 4-bit carry-in adder slice across the operand, one nibble per clock, least-significant nibble first. The carry is registered between slices. It presents the full-width sum and final carry-out over a second valid/ready handshake. It sits between operand producers (switch/register front ends) and display/accumulator consumers, replacing a full-width ripple adder where area matters more than latency.

## Interface
- `NIBBLES`, default 4: operand width in nibbles (W = 4*NIBBLES). Legal range 1..8.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: operands present.
- `in_ready` out 1: block is idle and can accept operands.
- `a` in W: operand A.
- `b` in W: operand B.
- `sub` in 1: selects subtract. Present only with `NIBBLE_ADD_SUB_EN`.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer takes the result.
- `sum` out W: result.
- `co` out 1: final carry-out (for subtract, 1 = no borrow).

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - `in_ready`=1.
  - On an edge with `in_valid`&`in_ready`: capture `a`, `b` (and `sub`) into operand registers; clear the nibble index to 0; load the carry register with 0 (or `sub` when SUB is enabled); go to ADD.
- ADD:
  - Each edge, the slice computes a[idx]+b'[idx]+carry. Here b' is `b`, or ~`b` when subtracting.
  - The slice writes its 4-bit result into `sum` nibble idx and its carry-out into the carry register, then increments idx.
  - On the edge that writes nibble NIBBLES-1, go to DONE.
- DONE:
  - `out_valid`=1; `co` = carry register.
  - `sum` and `co` hold stable until the edge with `out_valid`&`out_ready`, which returns the FSM to IDLE.
- Inputs change freely after the accept edge; only the captured copies are used.
- `in_valid` asserted in ADD or DONE is ignored (`in_ready`=0) and is not queued.
- `sum` bits not yet written in ADD keep their previous values. `sum` is only guaranteed while `out_valid`=1.
- Arithmetic is modulo 2^W. Carry out of the top slice goes to `co` only.
- Reset (any state, including mid-ADD):
  - FSM goes to IDLE and idx to 0.
  - `sum`, `co`, carry register and operand registers go to 0.
  - `out_valid` goes to 0 and `in_ready` to 1.
  - Any in-flight operation is discarded.

## Timing
- Accept at edge k. Nibble i is written at edge k+1+i. `out_valid` rises after edge k+NIBBLES, a latency of NIBBLES cycles.
- `in_ready` is 0 from after edge k until the cycle after result consumption.
- No overlap: the minimum period is NIBBLES+2 cycles per operation with `out_ready` held high.
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from inputs.
- Back-pressure: `out_ready`=0 in DONE holds all outputs indefinitely.

## Configuration
- `NIBBLE_ADD_SUB_EN` defined:
  - The `sub` port exists and is captured at accept.
  - `sub`=1 inverts `b` nibbles into the slice and seeds the carry with 1, giving two's-complement A−B.
- Not defined:
  - There is no `sub` port.
  - b' = `b` and the carry seed is 0 (add only).

## Structure
- Package `nibble_add_pkg`:
  - Holds the `NIBBLE_W`=4 constant.
  - Holds the FSM state enum typedef (IDLE/ADD/DONE).
  - Holds the index-width helper function ($clog2 of NIBBLES, minimum 1).
- One sub-module, `add4_ci`: a combinational 4-bit full-adder chain with carry-in, outputs S[3:0] and Co. It is instantiated exactly once.
- The FSM, operand/sum/carry registers and index counter live in the top.

## Test plan
- NIBBLES=4, `a`=0x1234, `b`=0x1111, `out_ready`=1 → `sum`=0x2345, `co`=0; `out_valid` 4 cycles after the accept edge, high for 1 cycle.
- `a`=0xFFFF, `b`=0x0001 → `sum`=0x0000, `co`=1. The carry propagates through all four slices via the carry register.
- `a`=0x00F0, `b`=0x0010 with `out_ready`=0 for 6 cycles → `sum`=0x0100 is held, `in_ready`=0 throughout. A second `in_valid` during this time is ignored. After `out_ready`=1: one handshake, then `in_ready`=1.
- `rst_n` pulsed low after 2 nibbles are written → `sum`=0, `co`=0, `out_valid`=0, `in_ready`=1 immediately. A subsequent 0x0001+0x0002 gives 0x0003.
- `NIBBLE_ADD_SUB_EN`:
  - 0x0007−0x0005 → `sum`=0x0002, `co`=1.
  - 0x0005−0x0007 → `sum`=0xFFFE, `co`=0.
- NIBBLES=1: `a`=0xF, `b`=0x1 → `sum`=0x0, `co`=1, `out_valid` 1 cycle after accept.
